cpl_queue_wrapper: RTL and testbench

CPL_QUEUE_WRAPPER -- requirements
Module: cpl_queue_wrapper

---
 rtl/cpl_queue_pkg.sv | 30 +++
 rtl/cpl_queue_wrapper_fifo.sv | 52 +++++
 rtl/cpl_queue_wrapper.sv | 145 ++++++++++++++
 tb/tb_cpl_queue_wrapper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpl_queue_pkg.sv
// Shared constants and types for the completion queue wrapper: mover states,
// entry geometry and the beat-0 header field positions.
package cpl_queue_pkg;

  localparam int BEAT_W          = 128;
  localparam int BEATS_PER_ENTRY = 8;
  localparam int BEAT_SHIFT      = 3;
  localparam int CNT_W           = 10;

  localparam int OPC_LSB = 96;
  localparam int OPC_MSB = 103;
  localparam int SEQ_LSB = 112;
  localparam int SEQ_MSB = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01
  } mover_st_e;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WR = 1'b1
  } src_e;

  // Free whole entries left in a FIFO holding 'beats' beats.
  function automatic logic [6:0] free_entries(input int depth, input logic [CNT_W-1:0] beats);
    return 7'(depth - int'(beats >> BEAT_SHIFT));
  endfunction

endpackage

// File: rtl/cpl_queue_wrapper_fifo.sv
// cpl_fifo: synchronous first-word-fall-through FIFO with beat count.
// Pushes while full and pops while empty are ignored.
module cpl_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 512,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [W-1:0]     din,
  input  logic             rd_en,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic [CNT_W-1:0] data_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full       = (r_cnt == CNT_W'(DEPTH));
  assign w_push     = wr_en & ~full;
  assign w_pop      = rd_en & (r_cnt != '0);
  assign dout       = r_mem[r_rptr];
  assign data_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cpl_queue_wrapper.sv
// Merges 8-beat read/write completion entries into one output queue with a
// round-robin mover. Define CPL_SEQ_STAMP_EN to stamp a sequence number in beat 0.
module cpl_queue_wrapper
  import cpl_queue_pkg::*;
#(
  parameter int         CPL_QUEUE_DEPTH = 64,
  parameter logic [7:0] RD_CPL_OPCODE   = 8'h81,
  parameter logic [7:0] WR_CPL_OPCODE   = 8'h82
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic [BEAT_W-1:0] rd_cpl_data_i,
  input  logic              rd_cpl_wr_en_i,
  output logic [6:0]        rd_cpl_av_o,
  input  logic [BEAT_W-1:0] wr_cpl_data_i,
  input  logic              wr_cpl_wr_en_i,
  output logic [6:0]        wr_cpl_av_o,
  output logic              cpl_empty_o,
  input  logic              cpl_rd_en_i,
  output logic [BEAT_W-1:0] cpl_data_o,
  output logic [6:0]        cpl_queue_av_o,
  output logic [31:0]       cpl_cnt_o,
  output logic              cpl_opcode_err_o,
  output logic              cpl_ovf_o
);
  localparam int FDEPTH = CPL_QUEUE_DEPTH * BEATS_PER_ENTRY;

  logic              w_rst;
  logic [BEAT_W-1:0] w_rd_head, w_wr_head, w_src_head, w_out_din;
  logic [CNT_W-1:0]  w_rd_cnt, w_wr_cnt, w_out_cnt;
  logic              w_rd_full, w_wr_full, w_out_full;
  logic              w_rd_rdy, w_wr_rdy, w_can_move;
  src_e              w_grant;
  logic [7:0]        w_exp_opc;

  mover_st_e   r_state;
  src_e        r_sel;
  src_e        r_last;
  logic        r_src_rd_en;
  logic        r_out_wr_en;
  logic [2:0]  r_beat;
  logic [31:0] r_cnt;
  logic        r_err;
  logic        r_ovf;

  // Disabling the block is treated exactly like a reset.
  assign w_rst = srst | ~en;

  cpl_fifo #(.W(BEAT_W), .DEPTH(FDEPTH), .CNT_W(CNT_W)) u_rd_fifo (
    .clk(clk), .srst(w_rst), .wr_en(rd_cpl_wr_en_i), .din(rd_cpl_data_i),
    .rd_en(r_src_rd_en & (r_sel == SRC_RD)), .dout(w_rd_head),
    .full(w_rd_full), .data_count(w_rd_cnt)
  );

  cpl_fifo #(.W(BEAT_W), .DEPTH(FDEPTH), .CNT_W(CNT_W)) u_wr_fifo (
    .clk(clk), .srst(w_rst), .wr_en(wr_cpl_wr_en_i), .din(wr_cpl_data_i),
    .rd_en(r_src_rd_en & (r_sel == SRC_WR)), .dout(w_wr_head),
    .full(w_wr_full), .data_count(w_wr_cnt)
  );

  cpl_fifo #(.W(BEAT_W), .DEPTH(FDEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk(clk), .srst(w_rst), .wr_en(r_out_wr_en), .din(w_out_din),
    .rd_en(cpl_rd_en_i), .dout(cpl_data_o),
    .full(w_out_full), .data_count(w_out_cnt)
  );

  assign rd_cpl_av_o    = free_entries(CPL_QUEUE_DEPTH, w_rd_cnt);
  assign wr_cpl_av_o    = free_entries(CPL_QUEUE_DEPTH, w_wr_cnt);
  assign cpl_queue_av_o = free_entries(CPL_QUEUE_DEPTH, w_out_cnt);
  assign cpl_empty_o    = ((w_out_cnt >> BEAT_SHIFT) == '0);

  assign w_rd_rdy   = ((w_rd_cnt >> BEAT_SHIFT) != '0);
  assign w_wr_rdy   = ((w_wr_cnt >> BEAT_SHIFT) != '0);
  assign w_can_move = (cpl_queue_av_o != '0) & ~w_out_full & (w_rd_rdy | w_wr_rdy);
  // On a tie the source not granted last time wins.
  assign w_grant    = (w_rd_rdy && (!w_wr_rdy || r_last == SRC_WR)) ? SRC_RD : SRC_WR;
  assign w_exp_opc  = (r_sel == SRC_WR) ? WR_CPL_OPCODE : RD_CPL_OPCODE;
  assign w_src_head = (r_sel == SRC_WR) ? w_wr_head : w_rd_head;

`ifdef CPL_SEQ_STAMP_EN
  logic [15:0] r_seq;

  always_comb begin
    w_out_din = w_src_head;
    if (r_beat == 3'd0) w_out_din[SEQ_MSB:SEQ_LSB] = r_seq;
  end

  always_ff @(posedge clk) begin
    if (w_rst)                                     r_seq <= '0;
    else if (r_state == ST_XFER && r_beat == 3'd0) r_seq <= r_seq + 1'b1;
  end
`else
  assign w_out_din = w_src_head;
`endif

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= SRC_RD;
      r_last      <= SRC_WR;
      r_src_rd_en <= 1'b0;
      r_out_wr_en <= 1'b0;
      r_beat      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (rd_cpl_wr_en_i & w_rd_full) | (wr_cpl_wr_en_i & w_wr_full);
      case (r_state)
        ST_IDLE: begin
          if (w_can_move) begin
            r_sel       <= w_grant;
            r_last      <= w_grant;
            r_src_rd_en <= 1'b1;
            r_out_wr_en <= 1'b1;
            r_beat      <= '0;
            r_cnt       <= r_cnt + 1'b1;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (r_beat == 3'd0 && w_src_head[OPC_MSB:OPC_LSB] != w_exp_opc) r_err <= 1'b1;
          if (r_beat == 3'(BEATS_PER_ENTRY-1)) begin
            r_src_rd_en <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: begin
          r_src_rd_en <= 1'b0;
          r_out_wr_en <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpl_cnt_o        = r_cnt;
  assign cpl_opcode_err_o = r_err;
  assign cpl_ovf_o        = r_ovf;

endmodule

// File: tb/tb_cpl_queue_wrapper.sv
// Scoreboard bench for cpl_queue_wrapper: per-source expected-beat queues,
// a host-side monitor popping whole entries, directed and random phases.
module tb_cpl_queue_wrapper;

  logic         clk = 1'b0;
  logic         srst, en;
  logic [127:0] rd_cpl_data_i, wr_cpl_data_i, cpl_data_o;
  logic         rd_cpl_wr_en_i, wr_cpl_wr_en_i, cpl_rd_en_i;
  logic [6:0]   rd_cpl_av_o, wr_cpl_av_o, cpl_queue_av_o;
  logic         cpl_empty_o, cpl_opcode_err_o, cpl_ovf_o;
  logic [31:0]  cpl_cnt_o;

  always #5 clk = ~clk;

  cpl_queue_wrapper dut (
    .clk(clk), .srst(srst), .en(en),
    .rd_cpl_data_i(rd_cpl_data_i), .rd_cpl_wr_en_i(rd_cpl_wr_en_i), .rd_cpl_av_o(rd_cpl_av_o),
    .wr_cpl_data_i(wr_cpl_data_i), .wr_cpl_wr_en_i(wr_cpl_wr_en_i), .wr_cpl_av_o(wr_cpl_av_o),
    .cpl_empty_o(cpl_empty_o), .cpl_rd_en_i(cpl_rd_en_i), .cpl_data_o(cpl_data_o),
    .cpl_queue_av_o(cpl_queue_av_o), .cpl_cnt_o(cpl_cnt_o),
    .cpl_opcode_err_o(cpl_opcode_err_o), .cpl_ovf_o(cpl_ovf_o)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           pop_budget = 0;
  logic [127:0] rd_exp[$];
  logic [127:0] wr_exp[$];
  int           got_src[$];
  bit           err_exp = 1'b0;
`ifdef CPL_SEQ_STAMP_EN
  logic [15:0]  exp_seq = '0;
`endif

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic clear_model();
    rd_exp.delete();
    wr_exp.delete();
    got_src.delete();
    err_exp = 1'b0;
`ifdef CPL_SEQ_STAMP_EN
    exp_seq = '0;
`endif
  endtask

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    clear_model();
  endtask

  // Push one 8-beat entry on either/both sources; beat 0 carries a source tag in [111:104].
  task automatic push(input bit do_rd, input bit do_wr, input logic [7:0] ro,
                      input logic [7:0] wo, input bit keep);
    logic [127:0] b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (do_rd) begin
        b = {$urandom, $urandom, $urandom, $urandom};
        if (i == 0) begin b[111:104] = 8'hA0; b[103:96] = ro; end
        rd_cpl_data_i = b; rd_cpl_wr_en_i = 1'b1;
        if (keep) rd_exp.push_back(b);
      end
      if (do_wr) begin
        b = {$urandom, $urandom, $urandom, $urandom};
        if (i == 0) begin b[111:104] = 8'hB0; b[103:96] = wo; end
        wr_cpl_data_i = b; wr_cpl_wr_en_i = 1'b1;
        if (keep) wr_exp.push_back(b);
      end
    end
    @(negedge clk);
    if (do_rd) rd_cpl_wr_en_i = 1'b0;
    if (do_wr) wr_cpl_wr_en_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    pop_budget = 100000;
    while (!(rd_exp.size() == 0 && wr_exp.size() == 0 && cpl_queue_av_o == 7'd64 &&
             rd_cpl_av_o == 7'd64 && wr_cpl_av_o == 7'd64) && n < 5000) begin
      @(negedge clk); n++;
    end
    n_vec++;
    if (n >= 5000) begin
      n_err++;
      $display("FAIL %s: drain timeout, rd left %0d wr left %0d", nm, rd_exp.size(), wr_exp.size());
    end
    repeat (3) @(negedge clk);
    pop_budget = 0;
  endtask

  task automatic rnd_pusher(input bit is_wr);
    logic [7:0] opc;
    bit wrong;
    int n;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      n = 0;
      while ((is_wr ? wr_cpl_av_o : rd_cpl_av_o) == 0 && n < 2000) begin @(negedge clk); n++; end
      wrong = ($urandom_range(0, 7) == 0);
      opc = (is_wr ? 8'h82 : 8'h81) ^ (wrong ? 8'h40 : 8'h00);
      if (wrong) err_exp = 1'b1;
      push(!is_wr, is_wr, opc, opc, 1'b1);
    end
  endtask

  // Host monitor: pops a whole entry whenever one is complete and budget remains.
  initial begin
    int src;
    logic [127:0] e;
    cpl_rd_en_i = 1'b0;
    src = 0;
    forever begin
      @(negedge clk);
      if (pop_budget > 0 && !cpl_empty_o && !srst && en) begin
        for (int b = 0; b < 8; b++) begin
          cpl_rd_en_i = 1'b1;
          if (b == 0) begin
            src = (cpl_data_o[111:104] == 8'hB0) ? 1 : 0;
            got_src.push_back(src);
          end
          if ((src == 1) ? (wr_exp.size() == 0) : (rd_exp.size() == 0)) begin
            n_vec++; n_err++;
            $display("FAIL out_beat: got %h expected nothing pending", cpl_data_o);
          end else begin
            e = (src == 1) ? wr_exp.pop_front() : rd_exp.pop_front();
`ifdef CPL_SEQ_STAMP_EN
            if (b == 0) begin e[127:112] = exp_seq; exp_seq++; end
`endif
            chk("out_beat", cpl_data_o, e);
          end
          @(negedge clk);
        end
        cpl_rd_en_i = 1'b0;
        pop_budget--;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int n;
    logic [3:0] ord;
    srst = 1'b1; en = 1'b1;
    rd_cpl_data_i = '0; wr_cpl_data_i = '0;
    rd_cpl_wr_en_i = 1'b0; wr_cpl_wr_en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", cpl_empty_o, 1);
    chk("rst_rd_av", rd_cpl_av_o, 64);
    chk("rst_wr_av", wr_cpl_av_o, 64);
    chk("rst_out_av", cpl_queue_av_o, 64);
    chk("rst_cnt", cpl_cnt_o, 0);
    chk("rst_err", cpl_opcode_err_o, 0);
    chk("rst_ovf", cpl_ovf_o, 0);
    srst = 1'b0;

    // Single rd entry: complete entry visible 9 cycles after the last push.
    push(1, 0, 8'h81, 8'h82, 1);
    n = 0;
    while (cpl_empty_o && n < 30) begin @(negedge clk); n++; end
    chk("rd_latency", n, 9);
    chk("cnt_one", cpl_cnt_o, 1);
    wait_drain("single");

    // Two simultaneous pairs: round-robin gives rd, wr, rd, wr.
    do_reset();
    push(1, 1, 8'h81, 8'h82, 1);
    push(1, 1, 8'h81, 8'h82, 1);
    n = 0;
    while (cpl_queue_av_o != 7'd62 && n < 100) begin @(negedge clk); n++; end
    chk("cnt_first_pair", cpl_cnt_o, 2);
    wait_drain("pairs");
    chk("arb_count", got_src.size(), 4);
    ord = '0;
    for (int i = 0; i < 4 && i < got_src.size(); i++) ord[i] = got_src[i][0];
    chk("arb_order", ord, 4'b1010);

    // Output full: pending rd entry waits until the host frees an entry.
    do_reset();
    repeat (64) push(1, 0, 8'h81, 8'h82, 1);
    n = 0;
    while (cpl_queue_av_o != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("out_full", cpl_queue_av_o, 0);
    push(1, 0, 8'h81, 8'h82, 1);
    repeat (20) @(negedge clk);
    chk("stall_out_av", cpl_queue_av_o, 0);
    chk("stall_rd_av", rd_cpl_av_o, 63);
    chk("stall_cnt", cpl_cnt_o, 64);
    pop_budget = 1;
    n = 0;
    while (rd_cpl_av_o != 7'd64 && n < 100) begin @(negedge clk); n++; end
    chk("resume_rd_av", rd_cpl_av_o, 64);
    chk("resume_cnt", cpl_cnt_o, 65);
    wait_drain("stall");

    // Source overflow and wrong opcode on the wr source.
    do_reset();
    repeat (128) push(1, 0, 8'h81, 8'h82, 1);
    n = 0;
    while ((rd_cpl_av_o != 0 || cpl_queue_av_o != 0) && n < 300) begin @(negedge clk); n++; end
    chk("src_full_av", rd_cpl_av_o, 0);
    chk("ovf_before", cpl_ovf_o, 0);
    push(1, 0, 8'h81, 8'h82, 0);
    chk("ovf_after", cpl_ovf_o, 1);
    push(0, 1, 8'h81, 8'h81, 1);
    chk("err_before_fwd", cpl_opcode_err_o, 0);
    wait_drain("ovf");
    chk("err_after_fwd", cpl_opcode_err_o, 1);

    // Reset during beat 4 of a transfer discards everything, including sticky flags.
    push(1, 0, 8'h81, 8'h82, 1);
    repeat (5) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    chk("midx_empty", cpl_empty_o, 1);
    chk("midx_cnt", cpl_cnt_o, 0);
    chk("midx_rd_av", rd_cpl_av_o, 64);
    chk("midx_out_av", cpl_queue_av_o, 64);
    chk("midx_flags", {cpl_ovf_o, cpl_opcode_err_o}, 2'b00);
    srst = 1'b0;
    clear_model();
    repeat (20) @(negedge clk);
    chk("midx_no_partial", {cpl_empty_o, cpl_queue_av_o}, {1'b1, 7'd64});

    // Dropping en flushes like a reset.
    push(1, 0, 8'h81, 8'h82, 1);
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_flush", {cpl_empty_o, rd_cpl_av_o, cpl_queue_av_o}, {1'b1, 7'd64, 7'd64});
    chk("en_cnt", cpl_cnt_o, 0);
    en = 1'b1;
    clear_model();
    repeat (20) @(negedge clk);
    chk("en_no_partial", {cpl_empty_o, cpl_queue_av_o}, {1'b1, 7'd64});

    // Random concurrent traffic on both sources with a live host.
    do_reset();
    pop_budget = 100000;
    fork
      rnd_pusher(1'b0);
      rnd_pusher(1'b1);
    join
    wait_drain("random");
    chk("rnd_cnt", cpl_cnt_o, 50);
    chk("rnd_err", cpl_opcode_err_o, err_exp);
    chk("rnd_ovf", cpl_ovf_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
